// File: rtl/stepmotor_mem_reader.sv
// stepmotor_mem_reader
// Streams a block of words from a latency-1 memory slave into a small FIFO.
// The sink drains the FIFO through a valid/ready stream. A read is issued only
// when the FIFO plus the one possible in-flight word still fits, so the FIFO
// never overflows. Reads are throttled by sink backpressure in that way.
module stepmotor_mem_reader #(
   parameter int ADDR_W     = 13,
   parameter int DATA_W     = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic [ADDR_W-1:0]   base_addr,
   input  logic [ADDR_W:0]     length,
   input  logic                abort,
   output logic                busy,
   output logic                done,
   output logic [ADDR_W-1:0]   avm_address,
   output logic                avm_chipselect,
   output logic                avm_write,
   output logic [DATA_W/8-1:0] avm_byteenable,
   input  logic [DATA_W-1:0]   avm_readdata,
   output logic [DATA_W-1:0]   st_data,
   output logic                st_valid,
   input  logic                st_ready,
   output logic                st_last
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W:0]    DEPTH_V = (CNT_W+1)'(FIFO_DEPTH);
   localparam logic [ADDR_W:0]   LEN_ONE = (ADDR_W+1)'(1);
   localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [ADDR_W:0]   issued_q, issued_d;
   logic [ADDR_W:0]   popped_q, popped_d;
   logic              inflight_q, inflight_d;
   logic              done_q, done_d;
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [DATA_W-1:0] mem_q [FIFO_DEPTH];

   logic              issue;
   logic              push;
   logic              pop;
   logic              room;
   logic              head_last;
   logic [ADDR_W-1:0] cur_addr;

   assign st_valid       = (count_q != '0);
   assign st_data        = mem_q[rd_ptr_q];
   assign st_last        = st_valid && head_last;
   assign busy           = (state_q != IDLE);
   assign done           = done_q;
   assign avm_chipselect = issue;
   assign avm_address    = issue ? cur_addr : addr_q;
   assign avm_write      = 1'b0;
   assign avm_byteenable = '1;

   // Issue qualification and FIFO handshake terms; abort blocks new traffic.
   always_comb begin
      cur_addr  = base_q + issued_q[ADDR_W-1:0];
      room      = ({1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q}) < DEPTH_V;
      issue     = (state_q == RUN) && !abort && (issued_q < len_q) && room;
      push      = inflight_q && !abort;
      pop       = st_valid && st_ready && !abort;
      head_last = (popped_q == (len_q - LEN_ONE));
   end

   // Next-state logic for the FSM, the block counters and the FIFO pointers.
   always_comb begin
      state_d    = state_q;
      base_d     = base_q;
      len_d      = len_q;
      issued_d   = issued_q;
      popped_d   = popped_q;
      addr_d     = addr_q;
      inflight_d = issue;
      done_d     = 1'b0;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;

      if (issue) begin
         addr_d   = cur_addr;
         issued_d = issued_q + LEN_ONE;
      end
      if (push) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
         popped_d = popped_q + LEN_ONE;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase

      case (state_q)
         IDLE: begin
            if (start) begin
               if (length != '0) begin
                  state_d  = RUN;
                  base_d   = base_addr;
                  len_d    = length;
                  issued_d = '0;
                  popped_d = '0;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         RUN: begin
            if (issue && ((issued_q + LEN_ONE) == len_q)) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && head_last) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (abort) begin
         state_d    = IDLE;
         done_d     = 1'b0;
         inflight_d = 1'b0;
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         count_d    = '0;
      end
   end

   // State, counter and pointer registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         base_q     <= '0;
         len_q      <= '0;
         issued_q   <= '0;
         popped_q   <= '0;
         addr_q     <= '0;
         inflight_q <= 1'b0;
         done_q     <= 1'b0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         state_q    <= state_d;
         base_q     <= base_d;
         len_q      <= len_d;
         issued_q   <= issued_d;
         popped_q   <= popped_d;
         addr_q     <= addr_d;
         inflight_q <= inflight_d;
         done_q     <= done_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

   // FIFO storage captures the read data one cycle after its issue.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= avm_readdata;
      end
   end

endmodule

// File: tb/tb_stepmotor_mem_reader.sv
// Directed testbench for stepmotor_mem_reader with a latency-1 memory model.
module tb_stepmotor_mem_reader;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [12:0] base_addr;
   logic [13:0] length;
   logic        abort;
   logic        busy;
   logic        done;
   logic [12:0] avm_address;
   logic        avm_chipselect;
   logic        avm_write;
   logic [3:0]  avm_byteenable;
   logic [31:0] avm_readdata = 32'h0;
   logic [31:0] st_data;
   logic        st_valid;
   logic        st_ready;
   logic        st_last;

   int          vectors = 0;
   int          miscompares = 0;
   int          doneCount = 0;
   logic [12:0] gotAddr[$];
   logic [31:0] gotData[$];
   logic        gotLast[$];

   stepmotor_mem_reader dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .start          (start),
      .base_addr      (base_addr),
      .length         (length),
      .abort          (abort),
      .busy           (busy),
      .done           (done),
      .avm_address    (avm_address),
      .avm_chipselect (avm_chipselect),
      .avm_write      (avm_write),
      .avm_byteenable (avm_byteenable),
      .avm_readdata   (avm_readdata),
      .st_data        (st_data),
      .st_valid       (st_valid),
      .st_ready       (st_ready),
      .st_last        (st_last)
   );

   always #5 clk = ~clk;

   // Memory contents are a fixed function of the word address.
   function automatic logic [31:0] memWord(input logic [12:0] a);
      return {6'h2A, a, ~a};
   endfunction

   // Latency-1 memory slave model
   always @(posedge clk) begin
      if (avm_chipselect) avm_readdata <= memWord(avm_address);
   end

   // Records issued addresses, accepted stream words and done pulses
   always @(negedge clk) begin
      if (reset_n) begin
         if (done) doneCount++;
         if (avm_chipselect) gotAddr.push_back(avm_address);
         if (st_valid && st_ready) begin
            gotData.push_back(st_data);
            gotLast.push_back(st_last);
         end
      end
   end

   // Guards against a hung run
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic s, input logic [12:0] b, input logic [13:0] len,
                                input logic ab, input logic rdy);
      start     = s;
      base_addr = b;
      length    = len;
      abort     = ab;
      st_ready  = rdy;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic waitDone(input int maxCycles, input int doneSnap);
      int n;
      n = 0;
      while (doneCount == doneSnap && n < maxCycles) begin
         nextCycle();
         n++;
      end
      checkOutput("done_within_bound", 32'(doneCount > doneSnap), 32'd1);
   endtask

   task automatic runBlock(input string tag, input logic [12:0] base, input logic [13:0] len);
      int sD, sA, sDone;
      sD    = gotData.size();
      sA    = gotAddr.size();
      sDone = doneCount;
      nextCycle();
      applyStimulus(1'b1, base, len, 1'b0, 1'b1);
      nextCycle();
      applyStimulus(1'b0, base, len, 1'b0, 1'b1);
      waitDone(int'(len) + 10, sDone);
      nextCycle();
      nextCycle();
      checkOutput({tag, "_done_once"}, 32'(doneCount - sDone), 32'd1);
      checkOutput({tag, "_word_count"}, 32'(gotData.size() - sD), 32'(len));
      checkOutput({tag, "_read_count"}, 32'(gotAddr.size() - sA), 32'(len));
      for (int i = 0; i < int'(len) && (sA + i) < gotAddr.size(); i++) begin
         logic [12:0] a;
         a = base + 13'(i);
         checkOutput({tag, "_addr"}, 32'(gotAddr[sA + i]), 32'(a));
      end
      for (int i = 0; i < int'(len) && (sD + i) < gotData.size(); i++) begin
         logic [12:0] a;
         a = base + 13'(i);
         checkOutput({tag, "_data"}, gotData[sD + i], memWord(a));
         checkOutput({tag, "_last"}, 32'(gotLast[sD + i]), 32'(i == int'(len) - 1));
      end
   endtask

   initial begin
      int snapDone, snapA, snapD;

      // Reset values
      reset_n = 1'b0;
      applyStimulus(1'b0, 13'h0, 14'd0, 1'b0, 1'b1);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_valid", 32'(st_valid), 32'd0);
      checkOutput("rst_last", 32'(st_last), 32'd0);
      checkOutput("rst_cs", 32'(avm_chipselect), 32'd0);
      checkOutput("rst_addr", 32'(avm_address), 32'd0);
      checkOutput("rst_write", 32'(avm_write), 32'd0);
      checkOutput("rst_be", 32'(avm_byteenable), 32'hF);
      nextCycle();
      nextCycle();
      reset_n = 1'b1;
      nextCycle();

      // Basic block, cycle accurate: base 0x10, length 4, sink always ready
      $display("[TB] block at 0x10, length 4");
      applyStimulus(1'b1, 13'h10, 14'd4, 1'b0, 1'b1);
      checkOutput("A_start_busy", 32'(busy), 32'd0);
      checkOutput("A_start_cs", 32'(avm_chipselect), 32'd0);
      for (int c = 1; c <= 8; c++) begin
         nextCycle();
         applyStimulus(1'b0, 13'h10, 14'd4, 1'b0, 1'b1);
         checkOutput("A_cs", 32'(avm_chipselect), 32'(c <= 4));
         checkOutput("A_addr", 32'(avm_address), (c <= 4) ? 32'(13'h10 + 13'(c - 1)) : 32'h13);
         checkOutput("A_valid", 32'(st_valid), 32'(c >= 3 && c <= 6));
         if (c >= 3 && c <= 6) checkOutput("A_data", st_data, memWord(13'h10 + 13'(c - 3)));
         checkOutput("A_last", 32'(st_last), 32'(c == 6));
         checkOutput("A_done", 32'(done), 32'(c == 7));
         checkOutput("A_busy", 32'(busy), 32'(c <= 6));
      end

      // Address wrap past the top of memory
      $display("[TB] wrapping block at 0x1FFE");
      runBlock("B", 13'h1FFE, 14'd4);

      // Backpressure: sink stalled for 20 cycles, start while busy is ignored
      $display("[TB] backpressure, length 10");
      snapDone = doneCount;
      snapA    = gotAddr.size();
      snapD    = gotData.size();
      nextCycle();
      applyStimulus(1'b1, 13'h100, 14'd10, 1'b0, 1'b0);
      for (int c = 1; c <= 20; c++) begin
         nextCycle();
         applyStimulus(c == 8, 13'h0AA, 14'd3, 1'b0, 1'b0);
         if (c == 10) begin
            checkOutput("C_mid_valid", 32'(st_valid), 32'd1);
            checkOutput("C_mid_data", st_data, memWord(13'h100));
         end
      end
      checkOutput("C_reads_stalled", 32'(gotAddr.size() - snapA), 32'd4);
      checkOutput("C_cs_stalled", 32'(avm_chipselect), 32'd0);
      checkOutput("C_valid_stalled", 32'(st_valid), 32'd1);
      checkOutput("C_data_stalled", st_data, memWord(13'h100));
      checkOutput("C_last_stalled", 32'(st_last), 32'd0);
      checkOutput("C_busy_stalled", 32'(busy), 32'd1);
      nextCycle();
      applyStimulus(1'b0, 13'h0, 14'd0, 1'b0, 1'b1);
      waitDone(60, snapDone);
      nextCycle();
      checkOutput("C_done_once", 32'(doneCount - snapDone), 32'd1);
      checkOutput("C_word_count", 32'(gotData.size() - snapD), 32'd10);
      checkOutput("C_read_count", 32'(gotAddr.size() - snapA), 32'd10);
      for (int i = 0; i < 10 && (snapD + i) < gotData.size(); i++) begin
         checkOutput("C_data", gotData[snapD + i], memWord(13'h100 + 13'(i)));
         checkOutput("C_last", 32'(gotLast[snapD + i]), 32'(i == 9));
      end

      // Zero length: no reads, never busy, one done pulse
      $display("[TB] zero length");
      snapDone = doneCount;
      snapA    = gotAddr.size();
      nextCycle();
      applyStimulus(1'b1, 13'h40, 14'd0, 1'b0, 1'b1);
      checkOutput("D_start_cs", 32'(avm_chipselect), 32'd0);
      nextCycle();
      applyStimulus(1'b0, 13'h40, 14'd0, 1'b0, 1'b1);
      checkOutput("D_done", 32'(done), 32'd1);
      checkOutput("D_busy", 32'(busy), 32'd0);
      checkOutput("D_cs", 32'(avm_chipselect), 32'd0);
      nextCycle();
      checkOutput("D_done_low", 32'(done), 32'd0);
      nextCycle();
      checkOutput("D_done_once", 32'(doneCount - snapDone), 32'd1);
      checkOutput("D_no_reads", 32'(gotAddr.size() - snapA), 32'd0);

      // Abort after the third issue, then abort racing a start in IDLE
      $display("[TB] abort mid-block");
      snapDone = doneCount;
      nextCycle();
      applyStimulus(1'b1, 13'h200, 14'd8, 1'b0, 1'b1);
      for (int c = 1; c <= 3; c++) begin
         nextCycle();
         applyStimulus(1'b0, 13'h200, 14'd8, 1'b0, 1'b1);
         checkOutput("E_cs", 32'(avm_chipselect), 32'd1);
         checkOutput("E_addr", 32'(avm_address), 32'(13'h200 + 13'(c - 1)));
      end
      nextCycle();
      applyStimulus(1'b0, 13'h200, 14'd8, 1'b1, 1'b1);
      nextCycle();
      applyStimulus(1'b0, 13'h200, 14'd8, 1'b0, 1'b1);
      checkOutput("E_busy_after", 32'(busy), 32'd0);
      checkOutput("E_valid_after", 32'(st_valid), 32'd0);
      checkOutput("E_cs_after", 32'(avm_chipselect), 32'd0);
      repeat (4) nextCycle();
      checkOutput("E_no_done", 32'(doneCount - snapDone), 32'd0);
      checkOutput("E_valid_later", 32'(st_valid), 32'd0);
      snapA = gotAddr.size();
      nextCycle();
      applyStimulus(1'b1, 13'h50, 14'd2, 1'b1, 1'b1);
      nextCycle();
      applyStimulus(1'b0, 13'h50, 14'd2, 1'b0, 1'b1);
      checkOutput("E_abort_start_busy", 32'(busy), 32'd0);
      repeat (3) nextCycle();
      checkOutput("E_abort_start_reads", 32'(gotAddr.size() - snapA), 32'd0);
      checkOutput("E_abort_start_done", 32'(doneCount - snapDone), 32'd0);
      runBlock("E2", 13'h300, 14'd3);

      // Reset while draining
      $display("[TB] reset during drain");
      snapDone = doneCount;
      nextCycle();
      applyStimulus(1'b1, 13'h400, 14'd3, 1'b0, 1'b0);
      for (int c = 1; c <= 5; c++) begin
         nextCycle();
         applyStimulus(1'b0, 13'h400, 14'd3, 1'b0, 1'b0);
      end
      checkOutput("F_busy_pre", 32'(busy), 32'd1);
      checkOutput("F_valid_pre", 32'(st_valid), 32'd1);
      checkOutput("F_cs_pre", 32'(avm_chipselect), 32'd0);
      checkOutput("F_data_pre", st_data, memWord(13'h400));
      reset_n = 1'b0;
      #1;
      checkOutput("F_rst_busy", 32'(busy), 32'd0);
      checkOutput("F_rst_done", 32'(done), 32'd0);
      checkOutput("F_rst_valid", 32'(st_valid), 32'd0);
      checkOutput("F_rst_last", 32'(st_last), 32'd0);
      checkOutput("F_rst_cs", 32'(avm_chipselect), 32'd0);
      checkOutput("F_rst_addr", 32'(avm_address), 32'd0);
      checkOutput("F_rst_write", 32'(avm_write), 32'd0);
      nextCycle();
      nextCycle();
      reset_n = 1'b1;
      applyStimulus(1'b0, 13'h0, 14'd0, 1'b0, 1'b1);
      repeat (5) nextCycle();
      checkOutput("F_no_done", 32'(doneCount - snapDone), 32'd0);
      checkOutput("F_busy_post", 32'(busy), 32'd0);
      checkOutput("F_valid_post", 32'(st_valid), 32'd0);

      // Single-word block after reset
      $display("[TB] single word block");
      runBlock("G", 13'h007, 14'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/stepmotor_mem_reader.md
STEPMOTOR_MEM_READER -- requirements
Module: stepmotor_mem_reader

Interface
REQ-001 SHALL have parameter ADDR_W, default 13, word-address width of the memory port.
REQ-002 SHALL have parameter DATA_W, default 32, data width.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, output buffer depth in words (power of two, >=2).
REQ-004 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port start  in  1  one-cycle request to begin a block read.
REQ-007 SHALL have port base_addr  in  ADDR_W  first word address, sampled with start.
REQ-008 SHALL have port length  in  ADDR_W+1  word count 0..2^ADDR_W, sampled with start.
REQ-009 SHALL have port abort  in  1  cancel the current transfer.
REQ-010 SHALL have port busy  out  1  transfer in progress.
REQ-011 SHALL have port done  out  1  one-cycle pulse on completion.
REQ-012 SHALL have port avm_address  out  ADDR_W  memory word address.
REQ-013 SHALL have port avm_chipselect  out  1  read strobe to the memory slave.
REQ-014 SHALL have port avm_write  out  1  constant 0.
REQ-015 SHALL have port avm_byteenable  out  DATA_W/8  constant all-ones.
REQ-016 SHALL have port avm_readdata  in  DATA_W  memory read data, fixed read latency 1.
REQ-017 SHALL have port st_data  out  DATA_W  streamed word.
REQ-018 SHALL have port st_valid  out  1  st_data valid.
REQ-019 SHALL have port st_ready  in  1  sink accepts when st_valid & st_ready.
REQ-020 SHALL have port st_last  out  1  high with the final word of a block.

Function
REQ-021 SHALL implement FSM states IDLE, RUN, DRAIN.
REQ-022 IDLE: start with length!=0 SHALL latch base_addr/length, clear counters, and enter RUN next cycle.
REQ-023 IDLE: start with length==0 SHALL stay in IDLE, issue no reads, and pulse done the following cycle.
REQ-024 RUN: read SHALL be issued (avm_chipselect=1) in a cycle only if issued<length and fifo_count+inflight<FIFO_DEPTH.
REQ-025 Issue n of a block SHALL drive avm_address = (base_addr+n) mod 2^ADDR_W, so reads wrap past the top address.
REQ-026 avm_readdata SHALL be written into the FIFO exactly one cycle after its issue cycle; inflight is 0 or 1.
REQ-027 Issues SHALL be back-to-back (one per cycle) while the sink is ready and the FIFO has room.
REQ-028 RUN SHALL go to DRAIN in the cycle after the last issue.
REQ-029 DRAIN SHALL go to IDLE when the last word is accepted on the stream; done SHALL pulse in the cycle after that acceptance.
REQ-030 FIFO SHALL present words in issue order; st_valid = FIFO non-empty; pop on st_valid & st_ready.
REQ-031 A simultaneous FIFO push and pop SHALL leave fifo_count unchanged; a push to a full FIFO SHALL never occur.
REQ-032 st_last SHALL be high only while the head word is word length-1 of the block.
REQ-033 st_data/st_valid/st_last SHALL stay stable while st_valid & ~st_ready.
REQ-034 busy SHALL be 1 in RUN and DRAIN, 0 in IDLE.
REQ-035 start while busy SHALL be ignored.
REQ-036 abort (any state) SHALL return to IDLE next cycle, flush the FIFO, discard any in-flight word, and suppress done; abort outranks start in the same cycle.
REQ-037 avm_address SHALL hold its last value when avm_chipselect=0.

Reset
REQ-038 reset_n low SHALL asynchronously force IDLE, empty FIFO, counters 0, inflight 0.
REQ-039 During and after reset: busy=0, done=0, st_valid=0, st_last=0, avm_chipselect=0, avm_address=0, avm_write=0.
REQ-040 Reset mid-transfer SHALL discard the transfer with no done pulse.

Verification
REQ-041 base_addr=0x10, length=4, st_ready=1 -> reads 0x10..0x13 on 4 consecutive cycles, 4 words streamed in order, st_last on 4th, done one cycle after 4th acceptance.
REQ-042 base_addr=0x1FFE, length=4 -> addresses 0x1FFE,0x1FFF,0x0000,0x0001.
REQ-043 length=10, st_ready=0 for 20 cycles -> exactly 4 reads issued then chipselect=0, st_valid=1 with word 0 stable; release st_ready -> all 10 words delivered, no loss or duplicate.
REQ-044 length=0 -> no chipselect, busy stays 0, done pulses once.
REQ-045 length=8, abort after 3rd issue -> IDLE next cycle, st_valid=0, no done; new start then runs normally.
REQ-046 reset_n asserted mid-DRAIN -> all outputs at reset values immediately, no done after release.
